// File: rtl/seg_scan_decoder.sv
// Recovers the four BCD digits, decimal points and frame timing from a
// multiplexed active-low 7-segment display bus by sampling segs/ssd_ctl.
module seg_scan_decoder #(
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] segs,
  input  logic [3:0] ssd_ctl,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] dp,
  output logic [3:0] err,
  output logic       valid,
  output logic       frame_done
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);
  localparam logic [3:0] CNT_ACC = 4'(STABLE_CNT - 1);

  logic [11:0] prev;
  logic [3:0]  cnt;
  logic [3:0]  seen;

  logic [11:0] sample;
  logic        legal;
  logic [1:0]  idx;
  logic        known;
  logic [3:0]  value;
  logic        same;
  logic        accept;
  logic [3:0]  seen_set;

  // A sample is only usable when exactly one digit enable is driven low.
  always_comb begin
    legal = 1'b1;
    idx   = 2'd0;
    case (ssd_ctl)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    known = 1'b1;
    value = 4'hF;
    case (segs[7:1])
      7'b0000001: value = 4'd0;
      7'b1001111: value = 4'd1;
      7'b0010010: value = 4'd2;
      7'b0000110: value = 4'd3;
      7'b1001100: value = 4'd4;
      7'b0100100: value = 4'd5;
      7'b0100000: value = 4'd6;
      7'b0001111: value = 4'd7;
      7'b0000000: value = 4'd8;
      7'b0000100: value = 4'd9;
      7'b1111111: value = 4'hF;
      default:    known = 1'b0;
    endcase
  end

  // Accept fires on the single edge where the dwell count reaches its limit.
  always_comb begin
    sample   = {ssd_ctl, segs};
    same     = (sample == prev);
    accept   = legal && same && (cnt == CNT_ACC);
    seen_set = seen | (4'b0001 << idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '1;
      cnt        <= 4'd0;
      seen       <= 4'd0;
      digit0     <= 4'hF;
      digit1     <= 4'hF;
      digit2     <= 4'hF;
      digit3     <= 4'hF;
      dp         <= 4'd0;
      err        <= 4'd0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!legal) begin
        cnt  <= 4'd0;
        prev <= '1;
      end else begin
        prev <= sample;
        if (!same)
          cnt <= 4'd1;
        else if (cnt != CNT_MAX)
          cnt <= cnt + 4'd1;
      end

      if (accept) begin
        // An unrecognised pattern flags err but keeps the last good digit.
        if (known) begin
          case (idx)
            2'd0: digit0 <= value;
            2'd1: digit1 <= value;
            2'd2: digit2 <= value;
            default: digit3 <= value;
          endcase
        end
        dp[idx]  <= ~segs[0];
        err[idx] <= ~known;
        if (seen_set == 4'hF) begin
          frame_done <= 1'b1;
          valid      <= 1'b1;
          seen       <= 4'd0;
        end else begin
          seen <= seen_set;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: a table of held samples with expected
// outputs, plus hand-written sequences for frame pulses, glitches and reset.
module tb_seg_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] segs;
  logic [3:0] ssd_ctl;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] dp, err;
  logic       valid, frame_done;

  int total = 0;
  int bad   = 0;

  seg_scan_decoder #(.STABLE_CNT(4)) dut (
    .clk(clk), .rst(rst), .segs(segs), .ssd_ctl(ssd_ctl),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .dp(dp), .err(err), .valid(valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;
    logic [7:0]  sg;
    int          cycles;
    logic [15:0] digits;   // {digit3, digit2, digit1, digit0}
    logic [3:0]  exp_dp;
    logic [3:0]  exp_err;
    logic        exp_valid;
    logic        exp_fd;
  } vec_t;

  vec_t vecs[15];

  // Segment patterns with dp off (bit 0 = 1).
  localparam logic [7:0] S0 = 8'b00000011;
  localparam logic [7:0] S1 = 8'b10011111;
  localparam logic [7:0] S2 = 8'b00100101;
  localparam logic [7:0] S3 = 8'b00001101;
  localparam logic [7:0] S4 = 8'b10011001;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold one sample for n rising edges, ending 1 time unit after the last edge.
  task automatic applyStimulus(input logic [3:0] ctl, input logic [7:0] sg, input int n);
    ssd_ctl = ctl;
    segs    = sg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " digits"}, {digit3, digit2, digit1, digit0}, 16'hFFFF);
    checkOutput({tag, " dp"}, {12'd0, dp}, 16'h0000);
    checkOutput({tag, " err"}, {12'd0, err}, 16'h0000);
    checkOutput({tag, " valid"}, {15'd0, valid}, 16'h0000);
    checkOutput({tag, " frame_done"}, {15'd0, frame_done}, 16'h0000);
  endtask

  initial begin
    vecs[0]  = '{4'b1101, S1,           6, 16'hFF13, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{4'b1011, 8'b01010101,  4, 16'hFF13, 4'b0000, 4'b0100, 1'b0, 1'b0};
    vecs[2]  = '{4'b1011, 8'b00000000,  4, 16'hF813, 4'b0100, 4'b0000, 1'b0, 1'b0};
    vecs[3]  = '{4'b1100, 8'b00000000, 10, 16'hF813, 4'b0100, 4'b0000, 1'b0, 1'b0};
    vecs[4]  = '{4'b1111, 8'b00000000, 10, 16'hF813, 4'b0100, 4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{4'b0111, S4,           3, 16'hF813, 4'b0100, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{4'b0111, S2,           3, 16'hF813, 4'b0100, 4'b0000, 1'b0, 1'b0};
    vecs[7]  = '{4'b0111, S2,           1, 16'h2813, 4'b0100, 4'b0000, 1'b1, 1'b1};
    vecs[8]  = '{4'b0111, S2,           1, 16'h2813, 4'b0100, 4'b0000, 1'b1, 1'b0};
    vecs[9]  = '{4'b1110, S1,           4, 16'h2811, 4'b0100, 4'b0000, 1'b1, 1'b0};
    vecs[10] = '{4'b1110, S2,           2, 16'h2811, 4'b0100, 4'b0000, 1'b1, 1'b0};
    vecs[11] = '{4'b1101, S2,           2, 16'h2811, 4'b0100, 4'b0000, 1'b1, 1'b0};
    vecs[12] = '{4'b1101, S2,           2, 16'h2821, 4'b0100, 4'b0000, 1'b1, 1'b0};
    vecs[13] = '{4'b1110, 8'b11111110,  4, 16'h282F, 4'b0101, 4'b0000, 1'b1, 1'b0};
    vecs[14] = '{4'b1110, 8'b11111110,  3, 16'h282F, 4'b0101, 4'b0000, 1'b1, 1'b0};

    rst     = 1'b1;
    ssd_ctl = 4'b1111;
    segs    = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetState("reset");

    // First digit: invisible after three edges, visible after the fourth.
    applyStimulus(4'b1110, S3, 3);
    checkOutput("latency digit0 early", {12'd0, digit0}, 16'h000F);
    applyStimulus(4'b1110, S3, 1);
    checkOutput("latency digit0", {12'd0, digit0}, 16'h0003);
    checkOutput("latency dp", {12'd0, dp}, 16'h0000);
    checkOutput("latency err", {12'd0, err}, 16'h0000);
    checkOutput("latency frame_done", {15'd0, frame_done}, 16'h0000);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].ctl, vecs[i].sg, vecs[i].cycles);
      checkOutput($sformatf("vec%0d digits", i), {digit3, digit2, digit1, digit0}, vecs[i].digits);
      checkOutput($sformatf("vec%0d dp", i), {12'd0, dp}, {12'd0, vecs[i].exp_dp});
      checkOutput($sformatf("vec%0d err", i), {12'd0, err}, {12'd0, vecs[i].exp_err});
      checkOutput($sformatf("vec%0d valid", i), {15'd0, valid}, {15'd0, vecs[i].exp_valid});
      checkOutput($sformatf("vec%0d frame_done", i), {15'd0, frame_done}, {15'd0, vecs[i].exp_fd});
    end

    // Full scan from reset: frame_done pulses once, on digit3's fourth edge.
    pulseReset();
    checkResetState("rescan reset");
    for (int d = 0; d < 4; d++) begin
      logic [7:0] pat;
      logic [3:0] ctl;
      case (d)
        0: pat = S1;
        1: pat = S2;
        2: pat = S3;
        default: pat = S4;
      endcase
      ctl = ~(4'b0001 << d);
      for (int k = 1; k <= 6; k++) begin
        applyStimulus(ctl, pat, 1);
        checkOutput($sformatf("scan d%0d k%0d frame_done", d, k), {15'd0, frame_done},
                    {15'd0, (d == 3 && k == 4)});
      end
      if (d == 2)
        checkOutput("scan valid before last", {15'd0, valid}, 16'h0000);
    end
    checkOutput("scan digits", {digit3, digit2, digit1, digit0}, 16'h4321);
    checkOutput("scan valid", {15'd0, valid}, 16'h0001);

    // Short dwell on a 0 pattern must never show up on digit1.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1101, S0, 1);
      checkOutput($sformatf("glitch k%0d digit1", k), {12'd0, digit1}, 16'h0002);
    end
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(4'b1101, S1, 1);
      checkOutput($sformatf("settle k%0d digit1", k), {12'd0, digit1}, (k == 4) ? 16'h0001 : 16'h0002);
    end

    // Reset lands on the edge that would have accepted; full dwell needed after.
    pulseReset();
    applyStimulus(4'b1110, S3, 3);
    checkOutput("pre-reset dwell digit0", {12'd0, digit0}, 16'h000F);
    pulseReset();
    checkResetState("mid-dwell reset");
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(4'b1110, S3, 1);
      checkOutput($sformatf("post-reset k%0d digit0", k), {12'd0, digit0}, (k == 4) ? 16'h0003 : 16'h000F);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
